inst_fetch_unit: RTL and testbench

- Responder for the control unit's fetch request. Takes a 1-cycle inst_fetch pulse plus the current pc and performs one read on the instruction bus.
- Instruction bus is a valid/ready address channel followed by a valid/ready data channel.
- Returns the fetched word with a 1-cycle inst_valid pulse, which the control unit's IDLE state waits on.
- Sits between the control unit / pc register and the instruction memory port.

---
 rtl/inst_fetch_unit.sv | 96 +++++++++
 tb/tb_inst_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch over a valid/ready address+data bus,
// with one queued request (last wins) and registered outputs.
module inst_fetch_unit #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_fetch,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic                  busy,
    output logic [PC_WIDTH-1:0]   ir_addr,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    input  logic [INST_WIDTH-1:0] ir_data,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t                state, state_n;
    logic [INST_WIDTH-1:0] inst_n;
    logic [PC_WIDTH-1:0]   addr_n, pending_pc, pending_pc_n;
    logic                  inst_valid_n, busy_n, addr_valid_n, data_ready_n, pending, pending_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            inst          <= '0;
            inst_valid    <= 1'b0;
            busy          <= 1'b0;
            ir_addr       <= '0;
            ir_addr_valid <= 1'b0;
            ir_data_ready <= 1'b0;
            pending       <= 1'b0;
            pending_pc    <= '0;
        end else begin
            state         <= state_n;
            inst          <= inst_n;
            inst_valid    <= inst_valid_n;
            busy          <= busy_n;
            ir_addr       <= addr_n;
            ir_addr_valid <= addr_valid_n;
            ir_data_ready <= data_ready_n;
            pending       <= pending_n;
            pending_pc    <= pending_pc_n;
        end
    end
    always_comb begin
        state_n      = state;
        inst_n       = inst;
        inst_valid_n = 1'b0;
        addr_n       = ir_addr;
        addr_valid_n = ir_addr_valid;
        data_ready_n = ir_data_ready;
        pending_n    = pending;
        pending_pc_n = pending_pc;
        case (state)
            ADDR: begin
                pending_n    = pending | inst_fetch;
                pending_pc_n = inst_fetch ? pc : pending_pc;
                if (ir_addr_valid && ir_addr_ready) begin
                    state_n      = DATA;
                    addr_valid_n = 1'b0;
                    data_ready_n = 1'b1;
                end
            end
            DATA: begin
                pending_n    = pending | inst_fetch;
                pending_pc_n = inst_fetch ? pc : pending_pc;
                if (ir_data_valid) begin
                    inst_n       = ir_data;
                    inst_valid_n = 1'b1;
                    data_ready_n = 1'b0;
                    // a request arriving with the data is chained directly, newest pc wins
                    if (pending || inst_fetch) begin
                        state_n      = ADDR;
                        addr_n       = inst_fetch ? pc : pending_pc;
                        addr_valid_n = 1'b1;
                        pending_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                if (inst_fetch) begin
                    state_n      = ADDR;
                    addr_n       = pc;
                    addr_valid_n = 1'b1;
                end
            end
        endcase
        busy_n = state_n != IDLE;
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed plan scenarios plus random bus traffic, checked against
// a transaction-level model (in-flight request + one queued request).
module tb_inst_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, inst_fetch = 1'b0, ir_addr_ready = 1'b0, ir_data_valid = 1'b0;
    logic [31:0] pc = '0, ir_data = '0;
    logic [31:0] inst, ir_addr;
    logic        inst_valid, busy, ir_addr_valid, ir_data_ready;
    int          checks = 0, errors = 0;
    logic        use_fixed = 1'b1;
    logic [31:0] fixed_word = '0;
    logic        m_busy = 1'b0, m_acc = 1'b0, m_q = 1'b0, m_iv = 1'b0;
    logic [31:0] m_addr = '0, m_qaddr = '0, m_inst = '0;

    inst_fetch_unit #(.PC_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .inst_fetch(inst_fetch), .pc(pc), .inst(inst),
        .inst_valid(inst_valid), .busy(busy), .ir_addr(ir_addr), .ir_addr_valid(ir_addr_valid),
        .ir_addr_ready(ir_addr_ready), .ir_data(ir_data), .ir_data_valid(ir_data_valid),
        .ir_data_ready(ir_data_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] dval(input logic [31:0] a);
        return use_fixed ? fixed_word : mem(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // drive one cycle's inputs at the negedge, then advance to the next negedge
    task automatic step(input logic f, input logic [31:0] p, input logic ar, input logic dv);
        inst_fetch    = f;
        pc            = p;
        ir_addr_ready = ar;
        ir_data_valid = dv;
        ir_data       = dv ? dval(m_addr) : $urandom;
        @(negedge clk);
    endtask

    task automatic drain(input int exp_pulses, input logic [31:0] exp_inst, input string tag);
        int pulses = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (inst_valid) pulses++;
        end
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_pulses"}, pulses, exp_pulses);
        check({tag, "_inst"}, inst, exp_inst);
    endtask

    // model: a request starts immediately when nothing is in flight, otherwise it
    // replaces the queued one; the queued one starts as soon as the data returns
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_acc = 1'b0; m_q = 1'b0; m_iv = 1'b0;
            m_addr = '0; m_qaddr = '0; m_inst = '0;
        end else begin
            m_iv = ir_data_ready && ir_data_valid;
            if (m_iv) m_inst = dval(m_addr);
            if (ir_addr_valid && ir_addr_ready) m_acc = 1'b1;
            if (inst_fetch) begin m_q = 1'b1; m_qaddr = pc; end
            if (m_iv) m_busy = 1'b0;
            if (!m_busy && m_q) begin
                m_busy = 1'b1; m_addr = m_qaddr; m_acc = 1'b0; m_q = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("m_inst_valid", {31'b0, inst_valid}, {31'b0, m_iv});
            check("m_inst", inst, m_inst);
            check("m_busy", {31'b0, busy}, {31'b0, m_busy});
            check("m_addr_valid", {31'b0, ir_addr_valid}, {31'b0, m_busy && !m_acc});
            check("m_data_ready", {31'b0, ir_data_ready}, {31'b0, m_busy && m_acc});
            if (m_busy && !m_acc) check("m_ir_addr", ir_addr, m_addr);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_inst", inst, 32'd0);
        check("rst_outs", {27'b0, inst_valid, busy, ir_addr_valid, ir_data_ready, 1'b0}, 32'd0);
        check("rst_addr", ir_addr, 32'd0);
        rst = 1'b0;
        // zero-wait fetch
        fixed_word = 32'h00500093;
        step(1'b1, 32'h100, 1'b1, 1'b1);
        check("zw_addr_valid", {31'b0, ir_addr_valid}, 32'd1);
        check("zw_addr", ir_addr, 32'h100);
        check("zw_busy", {31'b0, busy}, 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        check("zw_data_ready", {31'b0, ir_data_ready}, 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);
        check("zw_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("zw_inst", inst, 32'h00500093);
        check("zw_busy_low", {31'b0, busy}, 32'd0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("zw_pulse_once", {31'b0, inst_valid}, 32'd0);
        // address backpressure then data wait states
        fixed_word = 32'hDEADBEEF;
        step(1'b1, 32'h204, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", {31'b0, ir_addr_valid}, 32'd1);
            check("bp_addr", ir_addr, 32'h204);
            check("bp_no_ready", {31'b0, ir_data_ready}, 32'd0);
            step(1'b0, '0, 1'b0, 1'b1);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_data_ready", {31'b0, ir_data_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            check("dw_inst_hold", inst, 32'h00500093);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        check("dw_inst", inst, 32'hDEADBEEF);
        check("dw_valid", {31'b0, inst_valid}, 32'd1);
        // queued fetch
        use_fixed = 1'b0;
        step(1'b1, 32'h10, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h14, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("q_first", inst, mem(32'h10));
        check("q_no_idle", {31'b0, busy}, 32'd1);
        check("q_next_addr", ir_addr, 32'h14);
        drain(1, mem(32'h14), "q");
        // pending overwrite: only the last queued pc is fetched
        step(1'b1, 32'h30, 1'b0, 1'b0);
        step(1'b1, 32'h18, 1'b0, 1'b0);
        step(1'b1, 32'h1C, 1'b0, 1'b0);
        drain(2, mem(32'h1C), "ow");
        // fetch coincident with data handshake
        step(1'b1, 32'h40, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h20, 1'b1, 1'b1);
        check("co_valid", {31'b0, inst_valid}, 32'd1);
        check("co_inst", inst, mem(32'h40));
        check("co_addr_valid", {31'b0, ir_addr_valid}, 32'd1);
        check("co_addr", ir_addr, 32'h20);
        drain(1, mem(32'h20), "co");
        // asynchronous reset while in DATA
        step(1'b1, 32'h50, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("ar_in_data", {31'b0, ir_data_ready}, 32'd1);
        inst_fetch = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_outs", {29'b0, ir_data_ready, ir_addr_valid, busy}, 32'd0);
        check("ar_inst", inst, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        check("ar_refetch_valid", {31'b0, inst_valid}, 32'd1);
        check("ar_refetch_inst", inst, mem(32'h0));
        // random traffic against the model
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) == 0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 30 && busy; i++) step(1'b0, '0, 1'b1, 1'b1);
        check("final_idle", {31'b0, busy}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
